// File: rtl/d1_drain_ctrl.sv
// d1_drain_ctrl
//   Dequeue controller downstream of the D1 FIFO. It pops D1 while running
//   and the stage has room. A 3-entry skid buffer absorbs D1's one-cycle
//   registered read latency. Words go to the next stage with a push/full
//   handshake. Dropping enable flushes in-flight words, then returns to IDLE.
//
// Ports
//   clk, reset   : single clock, synchronous active-high reset
//   enable       : 1 = pop and forward, 0 = stop popping, drain, go idle
//   D1_empty     : D1 empty flag
//   D1_data_out  : D1 read data, valid the cycle after D1_rd
//   D1_rd        : pop strobe to D1
//   ds_full      : downstream cannot accept a word this cycle
//   ds_wr        : push strobe to downstream
//   ds_data      : pushed word (meaningful while ds_wr=1)
//   pop_count    : forwarded-word counter, wraps modulo 2^CNT_W
//   idle         : FSM is in IDLE
module d1_drain_ctrl #(
    parameter int BW    = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             D1_empty,
    input  logic [BW-1:0]    D1_data_out,
    output logic             D1_rd,
    input  logic             ds_full,
    output logic             ds_wr,
    output logic [BW-1:0]    ds_data,
    output logic [CNT_W-1:0] pop_count,
    output logic             idle
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    logic [1:0]    occ;
    logic          inflight;
    logic [1:0]    head;
    logic [1:0]    tail;
    logic [BW-1:0] skid [3];
    logic [BW-1:0] last_data;
    logic [2:0]    committed;

    // Words already buffered plus the one still coming back from D1.
    // Keeping this below 3 means no ds_full pattern can overflow the skid.
    assign committed = {1'b0, occ} + {2'b00, inflight};

    assign D1_rd   = (state == RUN) && !D1_empty && (committed < 3'd3);
    assign ds_wr   = (occ != 2'd0) && !ds_full;
    // Head while pushing, otherwise the last word pushed stays on the bus.
    assign ds_data = ds_wr ? skid[head] : last_data;
    assign idle    = (state == IDLE);

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            occ       <= '0;
            inflight  <= 1'b0;
            head      <= '0;
            tail      <= '0;
            last_data <= '0;
            pop_count <= '0;
        end else begin
            inflight <= D1_rd;
            occ      <= occ + {1'b0, inflight} - {1'b0, ds_wr};

            if (inflight) begin
                skid[tail] <= D1_data_out;
                tail       <= ptr_inc(tail);
            end

            if (ds_wr) begin
                last_data <= skid[head];
                head      <= ptr_inc(head);
                pop_count <= pop_count + CNT_W'(1);
            end

            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (!enable) state <= DRAIN;
                DRAIN:   if (occ == 2'd0 && !inflight) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/d1_drain_ctrl.md
# d1_drain_ctrl

Dequeue controller that sits directly downstream of the D1 FIFO in the QoS datapath. It pops D1 whenever D1 has data and the stage has room, absorbs D1's one-cycle registered read latency in a 3-entry skid buffer, and forwards words to the next stage with a push/full handshake. It sustains one word per cycle under no backpressure, never loses or duplicates a word under downstream stalls, and supports a clean drain-to-idle on disable.

## Interface
Parameters:
- BW, 4, data width; must equal the width of D1.
- CNT_W, 8, width of the forwarded-word counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = pop D1 and forward; 0 = stop popping, flush in-flight words, go idle.
- D1_empty  in  1  D1 empty flag.
- D1_data_out  in  BW  D1 read data; valid in the cycle after D1_rd=1 (registered read).
- D1_rd  out  1  pop strobe to D1.
- ds_full  in  1  downstream cannot accept a word this cycle.
- ds_wr  out  1  push strobe to downstream.
- ds_data  out  BW  word pushed; meaningful only when ds_wr=1.
- pop_count  out  CNT_W  number of words forwarded (ds_wr pulses), modulo 2^CNT_W.
- idle  out  1  1 when the FSM is in IDLE.

## Operation
- State: FSM {IDLE, RUN, DRAIN}; skid buffer of 3 entries, with occ in the range 0..3; inflight flag, which is D1_rd registered; pop_count.
- D1_rd = (state==RUN) && !D1_empty && (occ + inflight < 3). D1_rd is never asserted while D1_empty=1.
- Capture: when inflight=1, D1_data_out is written into the skid tail at the clock edge.
- ds_wr = (occ > 0) && !ds_full. ds_data = skid head, which is the oldest word. When ds_wr=0, ds_data holds the previous head value.
- occ_next = occ + inflight − ds_wr. A simultaneous capture and push is legal, and occ is unchanged in that case.
- The occ + inflight < 3 rule guarantees the skid never overflows under any ds_full pattern.
- pop_count increments by 1 on each ds_wr and wraps from 2^CNT_W−1 to 0.
- FSM transitions:
  - IDLE → RUN when enable=1.
  - RUN → DRAIN when enable=0.
  - DRAIN → IDLE when occ==0 && inflight==0.
  - In DRAIN, enable is ignored and D1_rd=0. Words already captured or in flight are still forwarded.
  - IDLE → RUN again requires enable=1 while in IDLE.
- Word order is strictly preserved from D1 to downstream.

## Timing
- Reset values: state IDLE, occ=0, inflight=0, D1_rd=0, ds_wr=0, ds_data=0, pop_count=0, idle=1.
- Reset mid-operation: all skid contents and any in-flight word are discarded. D1_data_out returned in the cycle after reset is ignored.
- Start-up: with enable=1 at cycle 0 (state IDLE), state is RUN in cycle 1, and the first D1_rd is issued in cycle 1 if D1 is non-empty.
- Latency: D1_rd in cycle t → word captured at the end of t+1 → ds_wr in cycle t+2. ds_wr can first be 1 in cycle 3 after enable rises.
- Throughput: with ds_full=0 and D1 non-empty, D1_rd=1 and ds_wr=1 every cycle in steady state.
- Backpressure: ds_full=1 freezes the head. At most 2 further words arrive: at most 1 in flight plus 1 more read allowed while occ + inflight < 3. occ saturates at 3 with D1_rd=0.
- enable falling in RUN: the read decision in that same cycle still uses state RUN, so one more D1_rd may issue. That word is forwarded during DRAIN.
- D1 going empty: D1_rd deasserts in the same cycle, combinationally from D1_empty. Words already buffered still drain.

## Test plan
- Streaming: after reset, preload D1 with 0x1..0x6, set enable=1, ds_full=0 → ds_wr high for 6 consecutive cycles from cycle 3, ds_data = 1,2,3,4,5,6, pop_count=6, D1_rd never high while D1_empty.
- Backpressure: stream 0x1..0x6 with ds_full=1 for cycles 4–9 → occ peaks at 3, D1_rd low while occ+inflight=3, output sequence exactly 1..6 with no loss or duplication, pop_count=6.
- Drain: stream 10 words, drop enable after the 4th ds_wr → every word popped from D1 is forwarded, then idle=1 and D1_rd=0. D1 still holds the remainder, and pop_count equals the number of D1_rd pulses.
- Simultaneous capture/push with alternating ds_full (1,0,1,0…) → ordering preserved and occ never exceeds 3.
- Counter wrap: CNT_W=4, forward 17 words → pop_count=1.
- Reset mid-stream: assert reset for one cycle while occ=2 and inflight=1 → next cycle all outputs are at reset values and no stale word is ever pushed.
